// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store unit controller: access sizes,
// one-hot byte-count masks, FSM states and the kind of operation in flight.
package lsu_ctrl_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'b00,
      SZ_HALF  = 2'b01,
      SZ_WORD  = 2'b10,
      SZ_DWORD = 2'b11
   } size_e;

   localparam logic [3:0] MASK_BYTE  = 4'b0001;
   localparam logic [3:0] MASK_HALF  = 4'b0010;
   localparam logic [3:0] MASK_WORD  = 4'b0100;
   localparam logic [3:0] MASK_DWORD = 4'b1000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_LOAD  = 2'd1,
      OP_STORE = 2'd2
   } op_e;

   function automatic logic [3:0] size_to_mask(input size_e sz);
      logic [3:0] m;
      case (sz)
         SZ_BYTE:  m = MASK_BYTE;
         SZ_HALF:  m = MASK_HALF;
         SZ_WORD:  m = MASK_WORD;
         default:  m = MASK_DWORD;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_align_chk.sv
// Combinational size decode: one-hot byte-count mask and natural-alignment
// check on the low address bits.
module lsu_align_chk
   import lsu_ctrl_pkg::*;
(
   input  logic [1:0] size_i,
   input  logic [2:0] addr_lo_i,
   output logic [3:0] mask_o,
   output logic       misalign_o
);

   size_e size;

   always_comb begin
      size       = size_e'(size_i);
      mask_o     = size_to_mask(size);
      misalign_o = 1'b0;
      case (size)
         SZ_BYTE:  misalign_o = 1'b0;
         SZ_HALF:  misalign_o = addr_lo_i[0];
         SZ_WORD:  misalign_o = |addr_lo_i[1:0];
         default:  misalign_o = |addr_lo_i[2:0];
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: registers one EXU request, drives the memory
// stage for LATENCY cycles, then holds the response until the WBU takes it.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int unsigned LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_addr,
   input  logic [63:0] in_wdata,
   input  logic        in_wen,
   input  logic        in_ren,
   input  logic [1:0]  in_size,
   input  logic        in_unsigned,
   input  logic [4:0]  in_rd,
   output logic        mem_write_en,
   output logic        mem_read_en,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_write_data,
   output logic [3:0]  mem_wmask,
   output logic [3:0]  mem_read_size,
   output logic        zero_extends,
   input  logic [63:0] mem_read_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic [4:0]  out_rd,
   output logic        out_rf_wen,
   output logic        out_misalign
);

   localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   op_e         op_q;
   logic [63:0] addr_q, wdata_q, data_q;
   logic [3:0]  mask_q;
   logic        zext_q, rf_wen_q, mis_q;
   logic [4:0]  rd_q;

   logic [3:0]  req_mask;
   logic        req_mis_raw, req_mis, is_mem, accept, last_access;

   lsu_align_chk u_align_chk (
      .size_i     (in_size),
      .addr_lo_i  (in_addr[2:0]),
      .mask_o     (req_mask),
      .misalign_o (req_mis_raw)
   );

   assign is_mem      = in_wen | in_ren;
   // Non-memory ops carry an ALU result in in_addr, so alignment is irrelevant.
   assign req_mis     = is_mem & req_mis_raw;
   assign accept      = in_valid && (state_q == IDLE);
   assign last_access = (state_q == ACCESS) && (cnt_q == LAST_CNT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = 4'd0;
            if (accept) begin
               state_d = (is_mem && !req_mis) ? ACCESS : RESP;
            end
         end
         ACCESS: begin
            if (last_access) begin
               state_d = RESP;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RESP: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // NOTE: reset is synchronous and active-high, so it lives inside the
   // clocked block; state uses non-blocking assignments so every register
   // updates from the same pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         op_q     <= OP_NONE;
         addr_q   <= '0;
         wdata_q  <= '0;
         data_q   <= '0;
         mask_q   <= '0;
         zext_q   <= 1'b0;
         rf_wen_q <= 1'b0;
         mis_q    <= 1'b0;
         rd_q     <= '0;
      end else if (accept) begin
         addr_q   <= in_addr;
         wdata_q  <= in_wdata;
         mask_q   <= req_mask;
         zext_q   <= in_unsigned;
         rd_q     <= in_rd;
         mis_q    <= req_mis;
         // A store wins when both enables are set.
         op_q     <= !is_mem ? OP_NONE : (in_wen ? OP_STORE : OP_LOAD);
         data_q   <= is_mem ? 64'd0 : in_addr;
         rf_wen_q <= !req_mis && !in_wen;
      end else if (last_access && (op_q == OP_LOAD)) begin
         data_q <= mem_read_data;
      end
   end

   assign in_ready       = (state_q == IDLE);
   assign mem_write_en   = (state_q == ACCESS) && (op_q == OP_STORE) && (cnt_q == 4'd0);
   assign mem_read_en    = (state_q == ACCESS) && (op_q == OP_LOAD);
   assign mem_addr       = addr_q;
   assign mem_write_data = wdata_q;
   assign mem_wmask      = mask_q;
   assign mem_read_size  = mask_q;
   assign zero_extends   = zext_q;

   assign out_valid      = (state_q == RESP);
   assign out_data       = data_q;
   assign out_rd         = rd_q;
   assign out_rf_wen     = rf_wen_q;
   assign out_misalign   = mis_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: two instances (LATENCY 1 and 3) driven with
// directed vectors; a negedge monitor compares responses against a queue.
module tb_lsu_ctrl;

   typedef struct packed {
      logic [63:0] data;
      logic [4:0]  rd;
      logic        rf_wen;
      logic        misalign;
   } resp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid [2];
   logic        out_ready [2];
   logic [63:0] in_addr, in_wdata, mem_rdata;
   logic        in_wen, in_ren, in_unsigned;
   logic [1:0]  in_size;
   logic [4:0]  in_rd;

   logic        in_ready [2];
   logic        mem_write_en [2];
   logic        mem_read_en [2];
   logic [63:0] mem_addr [2];
   logic [63:0] mem_write_data [2];
   logic [3:0]  mem_wmask [2];
   logic [3:0]  mem_read_size [2];
   logic        zero_extends [2];
   logic        out_valid [2];
   logic [63:0] out_data [2];
   logic [4:0]  out_rd [2];
   logic        out_rf_wen [2];
   logic        out_misalign [2];

   resp_t       q0[$];
   resp_t       q1[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          wr_seen [2] = '{0, 0};
   int          rd_seen [2] = '{0, 0};
   logic [3:0]  last_wmask [2];
   logic [3:0]  last_rsize [2];
   logic [63:0] last_waddr [2];
   logic [63:0] last_wdata [2];
   logic        last_zext [2];
   int          lat, wr_n, rd_n;

   always #5 clk = ~clk;

   lsu_ctrl #(.LATENCY(1)) dut_l1 (
      .clock(clk), .reset(reset),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_addr(in_addr), .in_wdata(in_wdata), .in_wen(in_wen), .in_ren(in_ren),
      .in_size(in_size), .in_unsigned(in_unsigned), .in_rd(in_rd),
      .mem_write_en(mem_write_en[0]), .mem_read_en(mem_read_en[0]),
      .mem_addr(mem_addr[0]), .mem_write_data(mem_write_data[0]),
      .mem_wmask(mem_wmask[0]), .mem_read_size(mem_read_size[0]),
      .zero_extends(zero_extends[0]), .mem_read_data(mem_rdata),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_data(out_data[0]), .out_rd(out_rd[0]),
      .out_rf_wen(out_rf_wen[0]), .out_misalign(out_misalign[0])
   );

   lsu_ctrl #(.LATENCY(3)) dut_l3 (
      .clock(clk), .reset(reset),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_addr(in_addr), .in_wdata(in_wdata), .in_wen(in_wen), .in_ren(in_ren),
      .in_size(in_size), .in_unsigned(in_unsigned), .in_rd(in_rd),
      .mem_write_en(mem_write_en[1]), .mem_read_en(mem_read_en[1]),
      .mem_addr(mem_addr[1]), .mem_write_data(mem_write_data[1]),
      .mem_wmask(mem_wmask[1]), .mem_read_size(mem_read_size[1]),
      .zero_extends(zero_extends[1]), .mem_read_data(mem_rdata),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_data(out_data[1]), .out_rd(out_rd[1]),
      .out_rf_wen(out_rf_wen[1]), .out_misalign(out_misalign[1])
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   task automatic mon(input int d);
      resp_t act, exp;
      if (mem_write_en[d] === 1'b1) begin
         wr_seen[d]++;
         last_wmask[d] = mem_wmask[d];
         last_waddr[d] = mem_addr[d];
         last_wdata[d] = mem_write_data[d];
      end
      if (mem_read_en[d] === 1'b1) begin
         rd_seen[d]++;
         last_rsize[d] = mem_read_size[d];
         last_zext[d]  = zero_extends[d];
      end
      if (out_valid[d] === 1'b1) begin
         act.data     = out_data[d];
         act.rd       = out_rd[d];
         act.rf_wen   = out_rf_wen[d];
         act.misalign = out_misalign[d];
         if (qsize(d) == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_resp dut%0d: got 0x%0h expected none", d, act);
         end else begin
            exp = (d == 0) ? q0[0] : q1[0];
            check($sformatf("resp_dut%0d", d), 128'(act), 128'(exp));
            if (out_ready[d] === 1'b1) begin
               if (d == 0) void'(q0.pop_front());
               else        void'(q1.pop_front());
            end
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   task automatic run_op(input int d, input logic wen, input logic ren,
                         input logic [1:0] size, input logic uns, input logic [4:0] rd,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] mrd, input logic [63:0] exp_data,
                         input logic exp_rf, input logic exp_mis, input int hold,
                         output int lat_o, output int wr_o, output int rd_o);
      resp_t e;
      int    wr0, rd0, busy_ready, guard;
      e.data = exp_data; e.rd = rd; e.rf_wen = exp_rf; e.misalign = exp_mis;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      in_wen = wen; in_ren = ren; in_size = size; in_unsigned = uns;
      in_rd = rd; in_addr = addr; in_wdata = wdata; mem_rdata = mrd;
      out_ready[d] = (hold == 0);
      wr0 = wr_seen[d];
      rd0 = rd_seen[d];
      in_valid[d] = 1'b1;
      @(posedge clk);
      #1 in_valid[d] = 1'b0;
      lat_o = 0;
      busy_ready = 0;
      do begin
         @(negedge clk);
         lat_o++;
         if (in_ready[d] === 1'b1) busy_ready++;
      end while (out_valid[d] !== 1'b1 && lat_o < 40);
      check($sformatf("out_valid_seen_dut%0d", d), out_valid[d], 1'b1);
      if (hold > 0) begin
         repeat (hold) begin
            @(negedge clk);
            if (in_ready[d] === 1'b1) busy_ready++;
         end
         @(posedge clk);
         #1 out_ready[d] = 1'b1;
      end
      guard = 0;
      while (qsize(d) != 0 && guard < 20) begin
         @(posedge clk);
         #1 guard++;
      end
      check($sformatf("busy_in_ready_dut%0d", d), busy_ready, 0);
      check($sformatf("queue_drained_dut%0d", d), qsize(d), 0);
      wr_o = wr_seen[d] - wr0;
      rd_o = rd_seen[d] - rd0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      in_valid[0] = 1'b0; in_valid[1] = 1'b0;
      out_ready[0] = 1'b1; out_ready[1] = 1'b1;
      in_addr = '0; in_wdata = '0; mem_rdata = '0;
      in_wen = 1'b0; in_ren = 1'b0; in_unsigned = 1'b0; in_size = 2'b00; in_rd = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_in_ready%0d", d), in_ready[d], 1'b1);
         check($sformatf("rst_out_valid%0d", d), out_valid[d], 1'b0);
         check($sformatf("rst_mem_en%0d", d), {mem_write_en[d], mem_read_en[d]}, 2'b00);
         check($sformatf("rst_mem_addr%0d", d), mem_addr[d], 64'd0);
         check($sformatf("rst_out_data%0d", d), out_data[d], 64'd0);
      end

      // Word load, LATENCY 1, sign already applied by memory stage
      run_op(0, 1'b0, 1'b1, 2'b10, 1'b0, 5'd3, 64'h8000_0004, 64'd0,
             64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0, 0, lat, wr_n, rd_n);
      check("ld_word_lat", lat, 2);
      check("ld_word_rd_en", rd_n, 1);
      check("ld_word_wr_en", wr_n, 0);

      // Half store
      run_op(0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd4, 64'h8000_0002, 64'h1234,
             64'd0, 64'd0, 1'b0, 1'b0, 0, lat, wr_n, rd_n);
      check("st_half_lat", lat, 2);
      check("st_half_wr_en", wr_n, 1);
      check("st_half_rd_en", rd_n, 0);
      check("st_half_wmask", last_wmask[0], 4'b0010);
      check("st_half_addr", last_waddr[0], 64'h8000_0002);
      check("st_half_wdata", last_wdata[0], 64'h1234);

      // Misaligned dword load
      run_op(0, 1'b0, 1'b1, 2'b11, 1'b0, 5'd5, 64'h8000_0004, 64'd0,
             64'hDEAD_BEEF, 64'd0, 1'b0, 1'b1, 0, lat, wr_n, rd_n);
      check("mis_ld_lat", lat, 1);
      check("mis_ld_en", wr_n + rd_n, 0);

      // Non-memory op
      run_op(0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd6, 64'h42, 64'd0,
             64'd0, 64'h42, 1'b1, 1'b0, 0, lat, wr_n, rd_n);
      check("alu_lat", lat, 1);
      check("alu_en", wr_n + rd_n, 0);

      // Both enables set: treated as a dword store
      run_op(0, 1'b1, 1'b1, 2'b11, 1'b0, 5'd7, 64'h8000_0008, 64'hCAFE_F00D_0000_0001,
             64'h5555, 64'd0, 1'b0, 1'b0, 0, lat, wr_n, rd_n);
      check("wr_rd_wr_en", wr_n, 1);
      check("wr_rd_rd_en", rd_n, 0);
      check("wr_rd_wmask", last_wmask[0], 4'b1000);

      // Unsigned byte load at odd address (bytes are never misaligned)
      run_op(0, 1'b0, 1'b1, 2'b00, 1'b1, 5'd8, 64'h8000_0007, 64'd0,
             64'hAB, 64'hAB, 1'b1, 1'b0, 0, lat, wr_n, rd_n);
      check("ld_byte_rd_en", rd_n, 1);
      check("ld_byte_rsize", last_rsize[0], 4'b0001);
      check("ld_byte_zext", last_zext[0], 1'b1);

      // Misaligned half store
      run_op(0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd9, 64'h8000_0001, 64'hBEEF,
             64'd0, 64'd0, 1'b0, 1'b1, 0, lat, wr_n, rd_n);
      check("mis_st_lat", lat, 1);
      check("mis_st_wr_en", wr_n, 0);

      // LATENCY 3 dword load with WBU stalled for 5 cycles
      run_op(1, 1'b0, 1'b1, 2'b11, 1'b0, 5'd10, 64'h8000_0010, 64'd0,
             64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 5, lat, wr_n, rd_n);
      check("ld3_lat", lat, 4);
      check("ld3_rd_en", rd_n, 3);
      check("ld3_rsize", last_rsize[1], 4'b1000);

      // Reset in the second ACCESS cycle of a LATENCY 3 load
      in_wen = 1'b0; in_ren = 1'b1; in_size = 2'b10; in_unsigned = 1'b0;
      in_rd = 5'd11; in_addr = 64'h8000_0020; mem_rdata = 64'h7777;
      in_valid[1] = 1'b1;
      @(posedge clk);
      #1 in_valid[1] = 1'b0;
      @(posedge clk);
      #1 check("rst_mid_rd_en_before", mem_read_en[1], 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check("rst_mid_in_ready", in_ready[1], 1'b1);
      check("rst_mid_en", {mem_write_en[1], mem_read_en[1]}, 2'b00);
      check("rst_mid_out_valid", out_valid[1], 1'b0);
      repeat (5) @(posedge clk);
      #1 check("rst_mid_no_resp", out_valid[1], 1'b0);

      // Recovery after reset
      run_op(1, 1'b0, 1'b0, 2'b11, 1'b0, 5'd12, 64'h1234_5678_9ABC_DEF0, 64'd0,
             64'd0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, 0, lat, wr_n, rd_n);
      check("recover_lat", lat, 1);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
